pipe_io_responder: RTL and testbench

PIPE_IO_RESPONDER -- requirements
Module: pipe_io_responder

---
 rtl/pipe_io_responder_pkg.sv | 61 ++++++
 rtl/pipe_io_responder_if.sv | 14 +
 rtl/hex_to_seg.sv | 9 +
 rtl/pipe_io_responder_debounce.sv | 64 ++++++
 rtl/pipe_io_responder.sv | 138 +++++++++++++
 tb/tb_pipe_io_responder.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/pipe_io_responder_pkg.sv
// Shared definitions for the pipeline IO responder: widths, register map,
// control layout, segment glyph table and the address decoder.
package pipe_io_responder_pkg;

  localparam int unsigned ADDR_W           = 8;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned SW_W             = 6;
  localparam int unsigned NUM_DIGITS       = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 16;

  localparam logic [ADDR_W-1:0] BASE_DEFAULT = 8'h80;

  localparam logic [ADDR_W-1:0] OFF_HEXVAL = 8'h00;
  localparam logic [ADDR_W-1:0] OFF_IN0    = 8'h04;
  localparam logic [ADDR_W-1:0] OFF_IN1    = 8'h08;
  localparam logic [ADDR_W-1:0] OFF_STATUS = 8'h0C;
  localparam logic [ADDR_W-1:0] OFF_CTRL   = 8'h10;
  localparam logic [ADDR_W-1:0] REG_SPAN   = 8'h14;

  typedef struct packed {
    logic [1:0] irq_en;
    logic [7:0] blank;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEXVAL,
    SEL_IN0,
    SEL_IN1,
    SEL_STATUS,
    SEL_CTRL
  } reg_sel_e;

  // Active-low gfedcba glyphs, entry 15 (F) first.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Maps a byte address to a register; the borrow bit rejects addresses below base.
  function automatic reg_sel_e decode_sel(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] off;
    off        = {1'b0, addr} - {1'b0, base};
    decode_sel = SEL_NONE;
    if (!off[ADDR_W] && (off[ADDR_W-1:0] < REG_SPAN)) begin
      case ({off[ADDR_W-1:2], 2'b00})
        OFF_HEXVAL: decode_sel = SEL_HEXVAL;
        OFF_IN0:    decode_sel = SEL_IN0;
        OFF_IN1:    decode_sel = SEL_IN1;
        OFF_STATUS: decode_sel = SEL_STATUS;
        OFF_CTRL:   decode_sel = SEL_CTRL;
        default:    decode_sel = SEL_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/pipe_io_responder_if.sv
// Memory-stage bus between the pipeline and the IO responder.
interface pipe_io_responder_if;
  import pipe_io_responder_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/hex_to_seg.sv
// Nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import pipe_io_responder_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_GLYPH[nib_i];
endmodule

// File: rtl/pipe_io_responder_debounce.sv
// One switch port: two-flop synchronizer, stability counter and committed value.
// chg_set_c pulses on the commit edge when the committed value changes.
module pipe_io_responder_debounce
  import pipe_io_responder_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int unsigned W        = SW_W
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] val_o,
  output logic         chg_set_c
);
  localparam int unsigned       CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [W-1:0]     sync1_q, sync1_d;
  logic [W-1:0]     sync2_q, sync2_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  // Counter saturates at CNT_MAX so a stable input keeps re-committing harmlessly.
  always_comb begin
    sync1_d   = sw_i;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    commit    = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      commit = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (commit) begin
      val_d = cand_q;
    end
    chg_set_c = commit && (cand_q != val_q);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign val_o = val_q;
endmodule

// File: rtl/pipe_io_responder.sv
// Memory-mapped IO responder: hex display value, debounced switch ports,
// change status with interrupt, single-cycle acknowledged register access.
module pipe_io_responder
  import pipe_io_responder_pkg::*;
#(
  parameter int unsigned       DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE     = BASE_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  pipe_io_responder_if.slave   bus_if,
  input  logic [SW_W-1:0]      sw0_i,
  input  logic [SW_W-1:0]      sw1_i,
  output logic [6:0]           hex0_o,
  output logic [6:0]           hex1_o,
  output logic [6:0]           hex2_o,
  output logic [6:0]           hex3_o,
  output logic [6:0]           hex4_o,
  output logic [6:0]           hex5_o,
  output logic [6:0]           hex6_o,
  output logic [6:0]           hex7_o,
  output logic                 irq_o
);

  logic [DATA_W-1:0] hexval_q, hexval_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [1:0]        status_q, status_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic [6:0]        hex_q [NUM_DIGITS];

  logic [SW_W-1:0]   in0, in1;
  logic [1:0]        chg_set;
  reg_sel_e          sel;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        status_clr;

  pipe_io_responder_debounce #(.DEBOUNCE(DEBOUNCE), .W(SW_W)) u_deb0 (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .sw_i      (sw0_i),
    .val_o     (in0),
    .chg_set_c (chg_set[0])
  );

  pipe_io_responder_debounce #(.DEBOUNCE(DEBOUNCE), .W(SW_W)) u_deb1 (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .sw_i      (sw1_i),
    .val_o     (in1),
    .chg_set_c (chg_set[1])
  );

  // Address decode and read mux from current register contents.
  always_comb begin
    sel   = decode_sel(bus_if.addr, BASE);
    wr_en = bus_if.req & bus_if.we;
    rd_en = bus_if.req & ~bus_if.we;
    case (sel)
      SEL_HEXVAL: rd_word = hexval_q;
      SEL_IN0:    rd_word = DATA_W'(in0);
      SEL_IN1:    rd_word = DATA_W'(in1);
      SEL_STATUS: rd_word = DATA_W'(status_q);
      SEL_CTRL:   rd_word = DATA_W'(ctrl_q);
      default:    rd_word = '0;
    endcase
  end

  // Next state; a switch change event in the same cycle beats a STATUS clear.
  always_comb begin
    hexval_d   = hexval_q;
    ctrl_d     = ctrl_q;
    status_clr = '0;
    if (wr_en) begin
      case (sel)
        SEL_HEXVAL: hexval_d   = bus_if.wdata;
        SEL_CTRL:   ctrl_d     = ctrl_t'(bus_if.wdata[CTRL_W-1:0]);
        SEL_STATUS: status_clr = bus_if.wdata[1:0];
        default:    ;
      endcase
    end
    status_d = (status_q & ~status_clr) | chg_set;
    irq_d    = |(status_q & ctrl_q.irq_en);
    ack_d    = bus_if.req;
    rdata_d  = rd_en ? rd_word : '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hexval_q <= '0;
      ctrl_q   <= '0;
      status_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      hexval_q <= hexval_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // Digits are registered from next-state values so they track writes on the ack edge.
  for (genvar n = 0; n < int'(NUM_DIGITS); n++) begin : g_digit
    logic [6:0] glyph;

    hex_to_seg u_dec (
      .nib_i (hexval_d[4*n +: 4]),
      .seg_o (glyph)
    );

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        hex_q[n] <= SEG_GLYPH[0];
      end else begin
        hex_q[n] <= ctrl_d.blank[n] ? SEG_BLANK : glyph;
      end
    end
  end

  assign bus_if.ack   = ack_q;
  assign bus_if.rdata = rdata_q;
  assign irq_o        = irq_q;
  assign hex0_o       = hex_q[0];
  assign hex1_o       = hex_q[1];
  assign hex2_o       = hex_q[2];
  assign hex3_o       = hex_q[3];
  assign hex4_o       = hex_q[4];
  assign hex5_o       = hex_q[5];
  assign hex6_o       = hex_q[6];
  assign hex7_o       = hex_q[7];

endmodule

// File: tb/tb_pipe_io_responder.sv
// Scoreboard bench for pipe_io_responder: stimulus queues expected read data,
// a monitor checks ack timing and rdata every cycle.
module tb_pipe_io_responder;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
  localparam logic [6:0] GA = 7'h08, GB = 7'h03, GC = 7'h46, GD = 7'h21;
  localparam logic [6:0] GX = 7'h7F;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sw0, sw1;
  logic [6:0] hex [8];
  logic       irq;
  logic       exp_ack;
  logic [7:0] op_id = 8'd0;
  exp_t       sb_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  pipe_io_responder_if bif ();

  pipe_io_responder dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus_if  (bif),
    .sw0_i   (sw0),
    .sw1_i   (sw1),
    .hex0_o  (hex[0]),
    .hex1_o  (hex[1]),
    .hex2_o  (hex[2]),
    .hex3_o  (hex[3]),
    .hex4_o  (hex[4]),
    .hex5_o  (hex[5]),
    .hex6_o  (hex[6]),
    .hex7_o  (hex[7]),
    .irq_o   (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_hex(input string name, input logic [7:0][6:0] exp);
    for (int n = 0; n < 8; n++)
      chk($sformatf("%s_hex%0d", name, n), 32'(hex[n]), 32'(exp[n]));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    bif.req   = 1'b1;
    bif.we    = w;
    bif.addr  = a;
    bif.wdata = d;
    sb_q.push_back({~w, exp, op_id});
    op_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bif.req = 1'b0;
    bif.we  = 1'b0;
  endtask

  // Monitor: ack must follow every non-reset req by one cycle; rdata checked on ack.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      exp_ack = bif.req && !rst;
      @(negedge clk);
      chk("ack", 32'(bif.ack), 32'(exp_ack));
      if (bif.ack) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: ack with no pending access");
        end else begin
          e = sb_q.pop_front();
          if (e.is_rd) chk($sformatf("rdata_op%0d", e.tag), bif.rdata, e.data);
        end
      end else begin
        chk("rdata_idle", bif.rdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sw0 = '0; sw1 = '0;
    bif.req = 1'b0; bif.we = 1'b0; bif.addr = '0; bif.wdata = '0;
    wait_cycles(3);
    chk_hex("rst", {8{G0}});
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    wait_cycles(20);

    // Display value and readback
    bus_op(1'b1, 8'h80, 32'h76543210, 32'd0);
    bus_op(1'b1, 8'h90, 32'h0, 32'd0);
    bus_idle();
    chk_hex("hexval", {G7, G6, G5, G4, G3, G2, G1, G0});
    bus_op(1'b0, 8'h80, 32'h0, 32'h76543210);
    bus_op(1'b0, 8'h83, 32'h0, 32'h76543210);
    bus_idle();

    // Blanking, CTRL masking, read-only and out-of-window accesses
    bus_op(1'b1, 8'h90, 32'h081, 32'd0);
    bus_idle();
    chk_hex("blank", {GX, G6, G5, G4, G3, G2, G1, GX});
    bus_op(1'b0, 8'h90, 32'h0, 32'h00000081);
    bus_op(1'b1, 8'h90, 32'hFFFFFC81, 32'd0);
    bus_op(1'b0, 8'h90, 32'h0, 32'h00000081);
    bus_op(1'b1, 8'h84, 32'h3F, 32'd0);
    bus_op(1'b0, 8'h84, 32'h0, 32'd0);
    bus_op(1'b1, 8'h94, 32'h1234, 32'd0);
    bus_op(1'b1, 8'h7C, 32'hDEAD, 32'd0);
    bus_op(1'b0, 8'h94, 32'h0, 32'd0);
    bus_op(1'b0, 8'h7C, 32'h0, 32'd0);
    bus_op(1'b0, 8'h80, 32'h0, 32'h76543210);

    // Switch commit, change flag and interrupt
    bus_op(1'b1, 8'h90, 32'h100, 32'd0);
    bus_idle();
    chk_hex("unblank", {G7, G6, G5, G4, G3, G2, G1, G0});
    sw0 = 6'h2A;
    wait_cycles(18);
    bus_op(1'b0, 8'h84, 32'h0, 32'd0);
    chk("irq_pre", 32'(irq), 32'd0);
    bus_op(1'b0, 8'h84, 32'h0, 32'h2A);
    chk("irq_set", 32'(irq), 32'd1);
    bus_op(1'b0, 8'h8C, 32'h0, 32'h1);
    bus_op(1'b1, 8'h8C, 32'h1, 32'd0);
    bus_idle();
    wait_cycles(1);
    chk("irq_clr", 32'(irq), 32'd0);
    bus_op(1'b0, 8'h8C, 32'h0, 32'd0);
    bus_idle();

    // Bouncing switch never commits
    for (int i = 0; i < 13; i++) begin
      sw1 = (i % 2 == 0) ? 6'h15 : 6'h00;
      wait_cycles(8);
    end
    sw1 = 6'h00;
    wait_cycles(24);
    bus_op(1'b0, 8'h88, 32'h0, 32'd0);
    bus_op(1'b0, 8'h8C, 32'h0, 32'd0);
    bus_idle();
    chk("bounce_irq", 32'(irq), 32'd0);

    // Back-to-back accesses
    bus_op(1'b1, 8'h80, 32'h0000ABCD, 32'd0);
    bus_op(1'b0, 8'h84, 32'h0, 32'h2A);
    bus_op(1'b0, 8'hF0, 32'h0, 32'd0);
    bus_idle();
    chk_hex("abcd", {G0, G0, G0, G0, GA, GB, GC, GD});
    bus_op(1'b0, 8'h80, 32'h0, 32'h0000ABCD);
    bus_idle();

    // Reset colliding with a write drops the access
    rst = 1'b1;
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = 8'h80; bif.wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_idle();
    chk("rst_wr_ack", 32'(bif.ack), 32'd0);
    chk_hex("rst_wr", {8{G0}});
    chk("rst_wr_irq", 32'(irq), 32'd0);
    bus_op(1'b0, 8'h80, 32'h0, 32'd0);
    bus_op(1'b0, 8'h90, 32'h0, 32'd0);
    bus_op(1'b0, 8'h84, 32'h0, 32'd0);
    bus_op(1'b0, 8'h8C, 32'h0, 32'd0);
    bus_idle();

    // Held switch recommits after reset and flags a change
    wait_cycles(20);
    bus_op(1'b0, 8'h8C, 32'h0, 32'h1);
    bus_op(1'b0, 8'h84, 32'h0, 32'h2A);
    bus_idle();
    chk("post_rst_irq", 32'(irq), 32'd0);

    wait_cycles(3);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
